// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches one- or two-byte instructions from instruction memory
//               at the address supplied by the program counter. It pulses the
//               PC enable after each byte and presents the decoded fields to
//               the control unit through a valid/ack handshake.
// Ports       : clk, reset       - clock, asynchronous active-high reset
//               start            - fetch request (IDLE/DONE only)
//               pc, pc_inc       - PC value in, one-cycle PC enable out
//               mem_req/addr     - memory read request and address
//               mem_ready/rdata  - memory read data handshake
//               instr_valid/ack  - instruction handshake to control unit
//               opcode, operand, imm, two_byte - latched instruction fields
//               busy, fetch_err  - activity indicator, sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_inc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic [7:0]        imm,
    output logic              two_byte,
    output logic              busy,
    output logic              fetch_err
);

    // Counter only needs to reach TIMEOUT-1; the abort fires on the cycle
    // that would bring it to TIMEOUT.
    localparam int               CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic             c_timeout_en = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_ADV1   = 3'd2,
        S_FETCH2 = 3'd3,
        S_ADV2   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_opcode;
    logic [3:0]       r_operand;
    logic [7:0]       r_imm;
    logic             r_two_byte;
    logic             r_fetch_err;
    logic             w_accept;     // a start is taken this cycle
    logic             w_timeout;    // fetch abandoned this cycle
    logic             w_enter_f2;   // moving from ADV1 into FETCH2

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_enter_f2  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        pc_inc      = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_FETCH1;
                    w_accept = 1'b1;
                end
            end
            S_FETCH1, S_FETCH2: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                busy     = 1'b1;
                if (mem_ready) begin
                    w_next = (r_state == S_FETCH1) ? S_ADV1 : S_ADV2;
                end else if (c_timeout_en && (r_cnt == c_cnt_last)) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_ADV1: begin
                pc_inc = 1'b1;
                busy   = 1'b1;
                // r_two_byte already holds bit 7 of the byte captured in FETCH1
                if (r_two_byte) begin
                    w_next     = S_FETCH2;
                    w_enter_f2 = 1'b1;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_ADV2: begin
                pc_inc = 1'b1;
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    if (start) begin
                        w_next   = S_FETCH1;
                        w_accept = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Wait counter, error flag and instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_fetch_err <= 1'b0;
            r_opcode    <= 4'h0;
            r_operand   <= 4'h0;
            r_imm       <= 8'h00;
            r_two_byte  <= 1'b0;
        end else begin
            if (w_accept || w_enter_f2) begin
                r_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_fetch_err <= 1'b0;
            end else if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end

            if ((r_state == S_FETCH1) && mem_ready) begin
                r_opcode   <= mem_rdata[7:4];
                r_operand  <= mem_rdata[3:0];
                r_two_byte <= mem_rdata[7];
                r_imm      <= 8'h00;
            end

            if ((r_state == S_FETCH2) && mem_ready) begin
                r_imm <= mem_rdata;
            end
        end
    end

    assign opcode    = r_opcode;
    assign operand   = r_operand;
    assign imm       = r_imm;
    assign two_byte  = r_two_byte;
    assign fetch_err = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. Contains a
//               byte-wide memory model and a PC model that advances on pc_inc;
//               expected instructions are queued when a fetch is started and
//               compared when instr_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] pc = '0;
    logic              pc_inc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [7:0]        mem_rdata;
    logic              instr_valid;
    logic              instr_ack;
    logic [3:0]        opcode;
    logic [3:0]        operand;
    logic [7:0]        imm;
    logic              two_byte;
    logic              busy;
    logic              fetch_err;

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .opcode      (opcode),
        .operand     (operand),
        .imm         (imm),
        .two_byte    (two_byte),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // Memory and program counter models
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    logic       pc_load;
    logic [7:0] pc_load_val;
    int         pc_inc_cnt = 0;

    always @(posedge clk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (pc_inc) pc <= pc + 8'd1;
    end

    always @(posedge clk) begin
        if (pc_inc) pc_inc_cnt++;
    end

    // Scoreboard
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] opd;
        logic [7:0] imm;
        logic       two;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   base;
    int   req_cycles;
    logic err_early;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic load_pc(input logic [7:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
        step();
        pc_load     = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b1, input logic [7:0] b2);
        exp_t e;
        e.op  = b1[7:4];
        e.opd = b1[3:0];
        e.two = b1[7];
        e.imm = b1[7] ? b2 : 8'h00;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
    endtask

    // exp_lat <= 0 skips the latency comparison
    task automatic wait_valid(input int exp_lat);
        int   n = 0;
        exp_t e;
        while (instr_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("valid_seen", instr_valid, 1);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("fields", {opcode, operand, imm, two_byte}, e);
        end
    endtask

    task automatic ack_instr();
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        check("valid_drop", instr_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b1;
        instr_ack = 1'b0;
        pc_load   = 1'b0;
        pc_load_val = 8'h00;

        // Reset state
        #1;
        check("reset_outs", {pc_inc, mem_req, mem_addr, instr_valid, opcode, operand,
                             imm, two_byte, busy, fetch_err}, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // One-byte instruction
        mem[8'h10] = 8'h3A;
        load_pc(8'h10);
        push_exp(8'h3A, 8'h00);
        base = pc_inc_cnt;
        pulse_start();
        check("t2_req", mem_req, 1);
        check("t2_addr", mem_addr, 8'h10);
        step();
        check("t2_pcinc", pc_inc, 1);
        wait_valid(3);
        check("t2_pcinc_cnt", pc_inc_cnt - base, 1);
        step();
        check("t2_valid_hold", instr_valid, 1);
        ack_instr();

        // Two-byte instruction
        mem[8'h20] = 8'h95;
        mem[8'h21] = 8'h7C;
        load_pc(8'h20);
        push_exp(8'h95, 8'h7C);
        base = pc_inc_cnt;
        pulse_start();
        check("t3_addr1", mem_addr, 8'h20);
        step();
        check("t3_pcinc1", pc_inc, 1);
        step();
        check("t3_req2", mem_req, 1);
        check("t3_addr2", mem_addr, 8'h21);
        wait_valid(5);
        check("t3_pcinc_cnt", pc_inc_cnt - base, 2);
        ack_instr();

        // Reset in the middle of FETCH2
        mem[8'h30] = 8'h81;
        mem[8'h31] = 8'h22;
        load_pc(8'h30);
        pulse_start();
        step();
        step();
        check("t1_in_fetch2", {mem_req, busy, mem_addr}, {1'b1, 1'b1, 8'h31});
        base  = pc_inc_cnt;
        reset = 1'b1;
        #1;
        check("t1_reset_outs", {pc_inc, mem_req, mem_addr, instr_valid, opcode, operand,
                                imm, two_byte, busy, fetch_err}, 0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("t1_no_pcinc", pc_inc_cnt - base, 0);
        check("t1_idle", {busy, instr_valid}, 0);
        push_exp(8'h22, 8'h00);
        pulse_start();
        check("t1_refetch_addr", mem_addr, 8'h31);
        wait_valid(3);
        ack_instr();

        // Memory wait states in FETCH1
        mem[8'h40] = 8'h5B;
        load_pc(8'h40);
        push_exp(8'h5B, 8'h00);
        mem_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check("t4_wait", {mem_req, busy, mem_addr}, {1'b1, 1'b1, 8'h40});
            step();
        end
        mem_ready = 1'b1;
        check("t4_capture_cycle", {mem_req, mem_addr}, {1'b1, 8'h40});
        step();
        check("t4_adv", {pc_inc, busy}, 2'b11);
        wait_valid(7);
        ack_instr();

        // Timeout: mem_ready never asserted
        load_pc(8'h50);
        mem_ready  = 1'b0;
        base       = pc_inc_cnt;
        req_cycles = 0;
        err_early  = 1'b0;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            if (mem_req) req_cycles++;
            err_early = err_early | fetch_err;
            step();
        end
        check("t5_req_cycles", req_cycles, TIMEOUT);
        check("t5_err_early", err_early, 0);
        check("t5_err", fetch_err, 1);
        check("t5_idle", {mem_req, busy, instr_valid}, 0);
        check("t5_no_pcinc", pc_inc_cnt - base, 0);
        step();
        step();
        check("t5_err_sticky", fetch_err, 1);
        mem_ready  = 1'b1;
        mem[8'h50] = 8'h17;
        push_exp(8'h17, 8'h00);
        pulse_start();
        check("t5_err_clear", fetch_err, 0);
        wait_valid(3);
        ack_instr();

        // Back-to-back fetch and start ignored while busy
        mem[8'h60] = 8'h42;
        mem[8'h61] = 8'h63;
        load_pc(8'h60);
        push_exp(8'h42, 8'h00);
        base = pc_inc_cnt;
        pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(3);
        step();
        check("t6_busy_start_ignored", {pc_inc_cnt - base, 1'b0, instr_valid}, {32'd1, 1'b0, 1'b1});
        push_exp(8'h63, 8'h00);
        instr_ack = 1'b1;
        start     = 1'b1;
        cyc       = 0;
        step();
        instr_ack = 1'b0;
        start     = 1'b0;
        check("t6_b2b", {mem_req, mem_addr, instr_valid, busy}, {1'b1, 8'h61, 1'b0, 1'b1});
        wait_valid(3);
        ack_instr();

        // PC wrap-around on a two-byte instruction
        mem[8'hFF] = 8'hC3;
        mem[8'h00] = 8'hEE;
        load_pc(8'hFF);
        push_exp(8'hC3, 8'hEE);
        pulse_start();
        check("wrap_addr1", mem_addr, 8'hFF);
        step();
        step();
        check("wrap_addr2", mem_addr, 8'h00);
        wait_valid(5);
        ack_instr();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
